// File: rtl/mmio_fifo_pkg.sv
// Register map offsets, STATUS/CTRL bit positions and the STATUS word layout
// shared by the MMIO FIFO controller and its storage.
package mmio_fifo_pkg;

    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_PEEK   = 3'd6;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_UNDERFLOW = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_FLUSH      = 0;
    localparam int CTRL_CLR_STICKY = 1;

    typedef struct packed {
        logic [47:0] rsvd_hi;
        logic [7:0]  count;
        logic [3:0]  rsvd_lo;
        logic        underflow;
        logic        overflow;
        logic        full;
        logic        empty;
    } status_t;

endpackage

// File: rtl/mmio_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W, write at clock edge, combinational read.
// Contents are deliberately not reset; occupancy tracking lives in the controller.
module mmio_fifo_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO register window (DATA/STATUS/CTRL/PEEK) over a small FIFO; read response 1 cycle, no backpressure.
// MMIO_FIFO_PEEK_EN builds the non-popping head read at +6; otherwise +6 reads 0.
module mmio_fifo_ctrl
    import mmio_fifo_pkg::*;
#(
    parameter int                DEPTH     = 8,
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(16'h0020)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_valid,
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic [8:0]                 rd_tid,
    output logic                       rsp_valid,
    output logic [8:0]                 rsp_tid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf, unf;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] rd_dat;
    status_t           status;

    logic [ADDR_W-1:0] rd_off, wr_off;
    logic rd_hit, wr_hit;
    logic pop_req, push_req, flush, clr_sticky;
    logic empty, full, pop_ok, push_ok, ovf_set, unf_set;

    // Window is +0..+6 above BASE_ADDR; the subtraction wraps for addresses below base.
    assign rd_off = rd_addr - BASE_ADDR;
    assign wr_off = wr_addr - BASE_ADDR;
    assign rd_hit = rd_valid && (rd_addr >= BASE_ADDR) && (rd_off <= ADDR_W'(6));
    assign wr_hit = wr_valid && (wr_addr >= BASE_ADDR) && (wr_off <= ADDR_W'(6));

    assign pop_req    = rd_hit && (rd_off[2:0] == OFF_DATA);
    assign push_req   = wr_hit && (wr_off[2:0] == OFF_DATA);
    assign flush      = wr_hit && (wr_off[2:0] == OFF_CTRL) && wr_data[CTRL_FLUSH];
    assign clr_sticky = wr_hit && (wr_off[2:0] == OFF_CTRL) && wr_data[CTRL_CLR_STICKY];

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign pop_ok  = pop_req && !empty;
    // A pop from a full FIFO frees the slot the simultaneous push needs.
    assign push_ok = push_req && (!full || pop_ok);
    assign ovf_set = push_req && !push_ok;
    assign unf_set = pop_req && empty;

    mmio_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_comb begin
        status           = '0;
        status.empty     = empty;
        status.full      = full;
        status.overflow  = ovf;
        status.underflow = unf;
        status.count     = 8'(cnt);
        rd_dat           = '0;
        case (rd_off[2:0])
            OFF_DATA:   if (pop_ok) rd_dat = head;
            OFF_STATUS: rd_dat = DATA_W'(status);
            OFF_PEEK: begin
`ifdef MMIO_FIFO_PEEK_EN
                if (!empty) rd_dat = head;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            rsp_valid <= rd_hit;
            rsp_tid   <= rd_tid;
            rsp_data  <= rd_dat;
            // Flush lands after the same-cycle read has been answered from the old state.
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
                cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
            end
            ovf <= (ovf && !clr_sticky) || ovf_set;
            unf <= (unf && !clr_sticky) || unf_set;
        end
    end

    assign fifo_count = cnt;

endmodule

// File: doc/mmio_fifo_ctrl.md
# mmio_fifo_ctrl

MMIO-facing controller that sequences a small on-chip FIFO behind a window of AFU user registers. Host writes to the DATA register push into the FIFO. Host reads of DATA pop the FIFO, and reads of STATUS return occupancy and error flags. Sits between the AFU's CCI-P MMIO decode (c0 rx write/read strobes) and the c2 read-response mux; it does not touch the DFH/AFU_ID addresses.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..128.
- DATA_W, 64: entry and MMIO data width.
- ADDR_W, 16: MMIO address width (32-bit-word units, CCI-P style).
- BASE_ADDR, 16'h0020: start of the register window.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- wr_valid  in  1  MMIO write strobe, one cycle.
- wr_addr  in  ADDR_W  MMIO write address.
- wr_data  in  DATA_W  MMIO write data.
- rd_valid  in  1  MMIO read strobe, one cycle.
- rd_addr  in  ADDR_W  MMIO read address.
- rd_tid  in  9  transaction ID of the read.
- rsp_valid  out  1  read response strobe.
- rsp_tid  out  9  echoed TID.
- rsp_data  out  DATA_W  read response data.
- fifo_count  out  $clog2(DEPTH+1)  current occupancy, for debug and top-level use.

## Operation
Register map (offsets from BASE_ADDR):
- +0 DATA: write pushes; read pops.
- +2 STATUS (RO): [0] empty, [1] full, [2] overflow sticky, [3] underflow sticky, [15:8] count zero-extended; other bits 0.
- +4 CTRL (WO): bit0 flush, bit1 clear sticky flags. Both are self-clearing; a read returns 0.
- +6 PEEK: see Configuration.

Read and write behaviour:
- A read to an address outside +0..+6 is a miss: no rsp_valid is generated, because the top level muxes other responders.
- A write to an address outside +0..+6, or to +2 or +6, is ignored.
- Push when full: data is dropped, count is unchanged, overflow is set.
- Pop when empty: response data is 0, pointers are unchanged, underflow is set.
- Push and pop in the same cycle:
  - Pop is evaluated against the state at the start of the cycle.
  - If full, both succeed and count is unchanged; overflow is not set.
  - If empty, pop returns 0 and sets underflow; the push lands normally. There is no bypass.
- Flush write with a read in the same cycle: the read is serviced against the pre-flush state, then pointers and count go to 0. Flush does not alter the sticky flags.
- A clear-sticky write in the same cycle as a new error: the new error wins and the flag stays set.
- Pointers wrap modulo DEPTH. Count saturates logically at DEPTH and never exceeds it.

## Timing
- Read latency is 1 cycle: a rd_valid hit in cycle N gives rsp_valid=1 in N+1 for exactly one cycle, with rsp_tid=rd_tid and rsp_data.
- Back-to-back reads produce back-to-back responses. No backpressure.
- Push, pop, flush and flag updates take effect at the clock edge ending the request cycle.
- STATUS and fifo_count reflect state before that cycle's updates.
- Reset (rst_n=0 at a clk edge) gives:
  - rsp_valid=0, rsp_tid=0, rsp_data=0.
  - pointers=0, fifo_count=0, empty=1, full=0, sticky flags=0.
- Storage contents are not reset.
- Reset mid-operation discards all pending entries. A response due in the reset cycle is suppressed.

## Configuration
- MMIO_FIFO_PEEK_EN defined: a read of +6 returns the head entry without popping. Returns 0 when empty; underflow is not set.
- MMIO_FIFO_PEEK_EN undefined: +6 is still a hit but always returns 0. No peek mux is built.

## Structure
- Package mmio_fifo_pkg holds:
  - register offset constants (OFF_DATA, OFF_STATUS, OFF_CTRL, OFF_PEEK);
  - STATUS bit-position constants;
  - CTRL bit constants;
  - a packed typedef for the STATUS word.
- Sub-module mmio_fifo_mem provides the storage array: DEPTH x DATA_W, synchronous write, combinational read by address.
- Pointers, count, flags and the response register live in mmio_fifo_ctrl.

## Test plan
- Reset, then read STATUS -> rsp_data=64'h1 (empty), rsp_valid one cycle after request, TID echoed.
- Push 64'hA, 64'hB, 64'hC, then three DATA reads -> responses A, B, C in order; STATUS then shows count 0 and empty.
- Push DEPTH+1 values, then read STATUS -> full=1, overflow=1, count=DEPTH; pops return the first DEPTH values and the extra value is lost.
- DATA read when empty -> rsp_data=0 and underflow=1; CTRL write 2'b10 -> underflow cleared on the next STATUS read.
- When full, push 64'hD and pop in the same cycle -> pop returns the oldest entry, count stays DEPTH, no overflow; 64'hD is read out last.
- Push 64'h5, read +6 -> with MMIO_FIFO_PEEK_EN the response is 64'h5 and count stays 1; without it the response is 0. A following flush then gives count 0.
